dds_param_ctrl: RTL and testbench

DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

---
 rtl/dds_param_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dds_param_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_param_ctrl.sv
// dds_param_ctrl: push-button front end for a DDS generator.
// Four raw active-low keys are synchronized, debounced and turned into
// press events. The events rotate the waveform, step the frequency word
// up or down, or cycle the amplitude.
//
// Ports:
//   sys_clk      - single clock domain
//   sys_rst_n    - asynchronous active-low reset
//   key[3:0]     - raw buttons, 0 = pressed
//   wave_select  - one-hot waveform: 0001 sine, 0010 square, 0100 triangle, 1000 sawtooth
//   freq_ctl     - phase-accumulator step word, kept within [FREQ_STEP, FREQ_MAX]
//   amp_ctl      - amplitude scale, 256 = full scale
//   param_vld    - one-cycle pulse in the cycle any output changes
//
// Build option: define DDS_PARAM_AUTOREPEAT_EN to add auto-repeat on key[1]/key[2].
// The first repeat fires HOLD_CYC+1 cycles after the press event, and later
// repeats fire every RATE_CYC+1 cycles.
module dds_param_ctrl #(
    parameter int unsigned CNT_MAX   = 999_999,
    parameter logic [31:0] FREQ_STEP = 32'd8589935,
    parameter logic [31:0] FREQ_MAX  = 32'd85899346,
    parameter int unsigned HOLD_CYC  = 24_999_999,
    parameter int unsigned RATE_CYC  = 4_999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  key,
    output logic [3:0]  wave_select,
    output logic [31:0] freq_ctl,
    output logic [8:0]  amp_ctl,
    output logic        param_vld
);

    localparam int unsigned CntW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    logic [3:0]           sync1_q, sync2_q;
    logic [1:0]           prime_q, prime_d;
    logic [3:0][CntW-1:0] db_cnt_q, db_cnt_d;
    logic [3:0]           stable_q, stable_d;
    logic [3:0]           armed_q, armed_d;
    logic [3:0]           press_q, press_d;
    logic [3:0]           ev;
    logic                 primed;

    // sync2_q only reflects the real keys two cycles after reset.
    // Before that it still holds the reset value.
    assign primed = (prime_q == 2'd2);
    assign prime_d = primed ? prime_q : prime_q + 2'd1;

    // Debounce: count while the synchronized sample disagrees with the stable level.
    // Any return to the stable level clears the count.
    // A key only becomes armed after it has been seen released.
    // This means a key held through reset gives no event until it is pressed again.
    always_comb begin
        db_cnt_d = '0;
        stable_d = stable_q;
        armed_d  = armed_q;
        press_d  = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == CntW'(CNT_MAX)) begin
                    stable_d[i] = sync2_q[i];
                    press_d[i]  = ~sync2_q[i] & armed_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
                end
            end
            if (primed && sync2_q[i] && stable_q[i]) begin
                armed_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            prime_q  <= 2'd0;
            db_cnt_q <= '0;
            stable_q <= 4'hF;
            armed_q  <= 4'h0;
            press_q  <= 4'h0;
        end else begin
            sync1_q  <= key;
            sync2_q  <= sync1_q;
            prime_q  <= prime_d;
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
        end
    end

`ifdef DDS_PARAM_AUTOREPEAT_EN
    localparam int unsigned RepMax = (HOLD_CYC > RATE_CYC) ? HOLD_CYC : RATE_CYC;
    localparam int unsigned RepW   = (RepMax > 0) ? $clog2(RepMax + 1) : 1;

    // Index 0 is key[1], index 1 is key[2].
    logic [1:0][RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]           rep_act_q, rep_act_d;
    logic [1:0]           rep_first_q, rep_first_d;
    logic [1:0]           rep_q, rep_d;

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_act_d   = rep_act_q;
        rep_first_d = rep_first_q;
        rep_d       = '0;
        for (int j = 0; j < 2; j++) begin
            if (press_d[j+1]) begin
                rep_act_d[j]   = 1'b1;
                rep_first_d[j] = 1'b1;
                rep_cnt_d[j]   = '0;
            end else if (stable_d[j+1]) begin
                rep_act_d[j] = 1'b0;
            end else if (rep_act_q[j]) begin
                if (rep_cnt_q[j] == (rep_first_q[j] ? RepW'(HOLD_CYC) : RepW'(RATE_CYC))) begin
                    rep_d[j]       = 1'b1;
                    rep_cnt_d[j]   = '0;
                    rep_first_d[j] = 1'b0;
                end else begin
                    rep_cnt_d[j] = rep_cnt_q[j] + RepW'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rep_cnt_q   <= '0;
            rep_act_q   <= '0;
            rep_first_q <= '0;
            rep_q       <= '0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_act_q   <= rep_act_d;
            rep_first_q <= rep_first_d;
            rep_q       <= rep_d;
        end
    end

    assign ev = press_q | {1'b0, rep_q, 1'b0};
`else
    assign ev = press_q;
`endif

    logic [3:0]  wave_q, wave_d;
    logic [31:0] freq_q, freq_d;
    logic [8:0]  amp_q, amp_d;
    logic        vld_q, vld_d;
    logic        wave_ok;
    logic [32:0] sum_up;

    assign wave_ok = (wave_q != 4'd0) && ((wave_q & (wave_q - 4'd1)) == 4'd0);
    assign sum_up  = {1'b0, freq_q} + {1'b0, FREQ_STEP};

    // Only the lowest-index event acts; the other simultaneous events are dropped.
    always_comb begin
        wave_d = wave_ok ? wave_q : 4'b0001;
        freq_d = freq_q;
        amp_d  = amp_q;
        if (ev[0]) begin
            wave_d = wave_ok ? {wave_q[2:0], wave_q[3]} : 4'b0001;
        end else if (ev[1]) begin
            freq_d = (sum_up > {1'b0, FREQ_MAX}) ? FREQ_MAX : sum_up[31:0];
        end else if (ev[2]) begin
            freq_d = ({1'b0, freq_q} >= {FREQ_STEP, 1'b0}) ? freq_q - FREQ_STEP : FREQ_STEP;
        end else if (ev[3]) begin
            amp_d = (amp_q == 9'd256 || amp_q == 9'd128 || amp_q == 9'd64) ? amp_q >> 1 : 9'd256;
        end
        // A saturated frequency step leaves everything unchanged, so it raises no pulse.
        vld_d = (wave_d != wave_q) || (freq_d != freq_q) || (amp_d != amp_q);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wave_q <= 4'b0001;
            freq_q <= FREQ_STEP;
            amp_q  <= 9'd256;
            vld_q  <= 1'b0;
        end else begin
            wave_q <= wave_d;
            freq_q <= freq_d;
            amp_q  <= amp_d;
            vld_q  <= vld_d;
        end
    end

    assign wave_select = wave_q;
    assign freq_ctl    = freq_q;
    assign amp_ctl     = amp_q;
    assign param_vld   = vld_q;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Bench for dds_param_ctrl, using short debounce and repeat times.
module tb_dds_param_ctrl;

    localparam int unsigned CNT_MAX  = 9;
    localparam int unsigned HOLD_CYC = 49;
    localparam int unsigned RATE_CYC = 19;
    localparam longint      STEP     = 64'd8589935;
    localparam longint      FMAX     = 64'd85899346;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key;
    logic [3:0]  wave_select;
    logic [31:0] freq_ctl;
    logic [8:0]  amp_ctl;
    logic        param_vld;

    int total = 0;
    int bad   = 0;

    int          vld_cnt  = 0;
    int          rep_mark = 1 << 30;
    logic [31:0] freq_at8 = '0;

    // Reference state, kept as plain numbers.
    int     m_widx;
    int     m_aidx;
    longint m_freq;
    int     amp_tab[4] = '{256, 128, 64, 32};

    typedef struct {
        logic [3:0]  mask;
        int          bounce;
        logic [3:0]  wave;
        logic [31:0] freq;
        logic [8:0]  amp;
        int          pulses;
    } vec_t;

    vec_t vecs[13];

    dds_param_ctrl #(
        .CNT_MAX  (CNT_MAX),
        .HOLD_CYC (HOLD_CYC),
        .RATE_CYC (RATE_CYC)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .key         (key),
        .wave_select (wave_select),
        .freq_ctl    (freq_ctl),
        .amp_ctl     (amp_ctl),
        .param_vld   (param_vld)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (param_vld) begin
            vld_cnt <= vld_cnt + 1;
            if (vld_cnt + 1 - rep_mark == 8) freq_at8 <= freq_ctl;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_widx = 0;
        m_aidx = 0;
        m_freq = STEP;
    endfunction

    function automatic void model_event(input logic [3:0] mask, output int changed);
        longint nf;
        changed = 0;
        if (mask[0]) begin
            m_widx  = (m_widx + 1) % 4;
            changed = 1;
        end else if (mask[1]) begin
            nf = m_freq + STEP;
            if (nf > FMAX) nf = FMAX;
            changed = (nf != m_freq) ? 1 : 0;
            m_freq  = nf;
        end else if (mask[2]) begin
            nf = m_freq - STEP;
            if (nf < STEP) nf = STEP;
            changed = (nf != m_freq) ? 1 : 0;
            m_freq  = nf;
        end else if (mask[3]) begin
            m_aidx  = (m_aidx + 1) % 4;
            changed = 1;
        end
    endfunction

    task automatic press(input logic [3:0] mask, input int bounce, input int hold);
        for (int b = 0; b < bounce; b++) begin
            key = ~mask;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            key = 4'hF;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        key = ~mask;
        repeat (hold) @(negedge clk);
        key = 4'hF;
        repeat (25) @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " wave"}, 32'(wave_select), 32'(1 << m_widx));
        chk({tag, " freq"}, freq_ctl, 32'(m_freq));
        chk({tag, " amp"}, 32'(amp_ctl), 32'(amp_tab[m_aidx]));
    endtask

    task automatic do_press(input logic [3:0] mask, input int bounce, input string tag);
        int ch;
        int v0;
        model_event(mask, ch);
        v0 = vld_cnt;
        press(mask, bounce, $urandom_range(20, 35));
        chk({tag, " pulses"}, 32'(vld_cnt - v0), 32'(ch));
        check_model(tag);
    endtask

    initial begin
        int v0;
        int n_ev;
        int ch;
        int exp_p;

        vecs[0]  = '{4'b0001, 2, 4'b0010, 32'd8589935,  9'd256, 1};
        vecs[1]  = '{4'b0001, 0, 4'b0100, 32'd8589935,  9'd256, 1};
        vecs[2]  = '{4'b0001, 1, 4'b1000, 32'd8589935,  9'd256, 1};
        vecs[3]  = '{4'b0001, 0, 4'b0001, 32'd8589935,  9'd256, 1};
        vecs[4]  = '{4'b1000, 1, 4'b0001, 32'd8589935,  9'd128, 1};
        vecs[5]  = '{4'b1000, 0, 4'b0001, 32'd8589935,  9'd64,  1};
        vecs[6]  = '{4'b1000, 0, 4'b0001, 32'd8589935,  9'd32,  1};
        vecs[7]  = '{4'b1000, 0, 4'b0001, 32'd8589935,  9'd256, 1};
        vecs[8]  = '{4'b1001, 0, 4'b0010, 32'd8589935,  9'd256, 1};
        vecs[9]  = '{4'b0010, 0, 4'b0010, 32'd17179870, 9'd256, 1};
        vecs[10] = '{4'b0100, 0, 4'b0010, 32'd8589935,  9'd256, 1};
        vecs[11] = '{4'b0100, 0, 4'b0010, 32'd8589935,  9'd256, 0};
        vecs[12] = '{4'b0110, 0, 4'b0010, 32'd17179870, 9'd256, 1};

        // Reset state, and idle keys after release.
        key   = 4'hF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst wave", 32'(wave_select), 32'd1);
        chk("rst freq", freq_ctl, 32'd8589935);
        chk("rst amp", 32'(amp_ctl), 32'd256);
        chk("rst vld", 32'(param_vld), 32'd0);
        rst_n = 1'b1;
        v0 = vld_cnt;
        repeat (30) @(negedge clk);
        chk("idle pulses", 32'(vld_cnt - v0), 32'd0);
        chk("idle wave", 32'(wave_select), 32'd1);
        chk("idle freq", freq_ctl, 32'd8589935);

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            v0 = vld_cnt;
            press(vecs[i].mask, vecs[i].bounce, 25);
            chk($sformatf("vec%0d pulses", i), 32'(vld_cnt - v0), 32'(vecs[i].pulses));
            chk($sformatf("vec%0d wave", i), 32'(wave_select), 32'(vecs[i].wave));
            chk($sformatf("vec%0d freq", i), freq_ctl, vecs[i].freq);
            chk($sformatf("vec%0d amp", i), 32'(amp_ctl), 32'(vecs[i].amp));
        end
        m_widx = 1;
        m_freq = 2 * STEP;
        m_aidx = 0;

        // Latency from a raw edge to the update is 2 + CNT_MAX + 2 cycles.
        key = 4'b1110;
        repeat (CNT_MAX + 3) @(negedge clk);
        chk("lat early vld", 32'(param_vld), 32'd0);
        chk("lat early wave", 32'(wave_select), 32'(1 << m_widx));
        model_event(4'b0001, ch);
        @(negedge clk);
        chk("lat vld", 32'(param_vld), 32'd1);
        chk("lat wave", 32'(wave_select), 32'(1 << m_widx));
        @(negedge clk);
        chk("lat vld pulse width", 32'(param_vld), 32'd0);
        key = 4'hF;
        repeat (25) @(negedge clk);

        // Frequency saturation at both ends.
        do_press(4'b0100, 0, "down0");
        for (int i = 0; i < 10; i++) begin
            v0 = vld_cnt;
            do_press(4'b0010, 0, $sformatf("up%0d", i));
            if (i == 8) chk("ceiling", freq_ctl, 32'd85899346);
            if (i == 9) chk("ceiling no vld", 32'(vld_cnt - v0), 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            do_press(4'b0100, 0, $sformatf("dn%0d", i));
        end
        chk("floor", freq_ctl, 32'd8589935);

        // Random presses against the model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0] m;
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15))
                                            : 4'(1 << $urandom_range(0, 3));
            do_press(m, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        // Reset during debounce of key[3]; the key stays held afterwards.
        do_press(4'b1000, 0, "pre-rst amp");
        key = 4'b0111;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst amp", 32'(amp_ctl), 32'd256);
        chk("midrst wave", 32'(wave_select), 32'd1);
        chk("midrst freq", freq_ctl, 32'd8589935);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = vld_cnt;
        repeat (40) @(negedge clk);
        chk("held thru rst pulses", 32'(vld_cnt - v0), 32'd0);
        chk("held thru rst amp", 32'(amp_ctl), 32'd256);
        key = 4'hF;
        repeat (30) @(negedge clk);
        do_press(4'b1000, 0, "re-press");

        // key[1] held for 200 cycles.
        v0 = vld_cnt;
        rep_mark = vld_cnt;
        key = 4'b1101;
        repeat (200) @(negedge clk);
        key = 4'hF;
        repeat (40) @(negedge clk);
        n_ev = 1;
`ifdef DDS_PARAM_AUTOREPEAT_EN
        // Times are counted in edges from the raw change: the press is taken at CNT_MAX+3.
        // The release is taken at 200+CNT_MAX+3.
        for (int t = int'(CNT_MAX + 3 + HOLD_CYC + 1); t < int'(200 + CNT_MAX + 3);
             t += int'(RATE_CYC + 1)) begin
            n_ev++;
        end
`endif
        exp_p = 0;
        for (int e = 0; e < n_ev; e++) begin
            model_event(4'b0010, ch);
            exp_p += ch;
        end
        chk("hold pulses", 32'(vld_cnt - v0), 32'(exp_p));
        check_model("hold");
`ifdef DDS_PARAM_AUTOREPEAT_EN
        chk("hold freq at 8th", freq_at8, 32'd77309415);
`else
        chk("hold single step", freq_ctl, 32'd17179870);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
